// File: rtl/gcd_engine_param_if.sv
// Request/response bundle between a sequencer (master) and the GCD engine (slave).
// Parameters must match those of the gcd_engine_param instance attached to it.
interface gcd_engine_param_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd_out;
    logic [CNT_W-1:0] iter_count;
    logic             zero_in;

    modport master (
        output start, mode, a_in, b_in,
        input  busy, done, gcd_out, iter_count, zero_in
    );

    modport slave (
        input  start, mode, a_in, b_in,
        output busy, done, gcd_out, iter_count, zero_in
    );
endinterface

// File: rtl/gcd_engine_param.sv
// Parametrised GCD engine: subtractive (Euclid) or binary (Stein) algorithm selected per
// operation, parallel operand load, registered done/result/iteration-count/zero-flag outputs.
module gcd_engine_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    gcd_engine_param_if.slave  bus
);
    localparam int unsigned K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [K_W-1:0]   k_r;
    logic             mode_r;
    logic             busy_r;
    logic             done_r;
    logic             zero_r;
    logic [WIDTH-1:0] gcd_r;
    logic [CNT_W-1:0] iter_r;

    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] b_nx;
    logic             k_inc;

    // One algorithm step on the current operands; only applied when A != B.
    always_comb begin
        a_nx  = a_r;
        b_nx  = b_r;
        k_inc = 1'b0;
        if (!mode_r) begin
            if (a_r > b_r) a_nx = a_r - b_r;
            else           b_nx = b_r - a_r;
        end else if (!a_r[0] && !b_r[0]) begin
            a_nx  = a_r >> 1;
            b_nx  = b_r >> 1;
            k_inc = 1'b1;
        end else if (!a_r[0]) begin
            a_nx = a_r >> 1;
        end else if (!b_r[0]) begin
            b_nx = b_r >> 1;
        end else if (a_r > b_r) begin
            a_nx = a_r - b_r;
        end else begin
            b_nx = b_r - a_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            k_r    <= '0;
            mode_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            zero_r <= 1'b0;
            gcd_r  <= '0;
            iter_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_r    <= bus.a_in;
                        b_r    <= bus.b_in;
                        mode_r <= bus.mode;
                        k_r    <= '0;
                        iter_r <= '0;
                        if (bus.a_in == '0 || bus.b_in == '0) begin
                            // gcd(x,0) = x, and OR-ing also yields gcd(0,0) = 0
                            state  <= DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            zero_r <= 1'b1;
                            gcd_r  <= bus.a_in | bus.b_in;
                        end else begin
                            state  <= CALC;
                            busy_r <= 1'b1;
                            zero_r <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (a_r == b_r) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        gcd_r  <= mode_r ? (a_r << k_r) : a_r;
                    end else begin
                        a_r <= a_nx;
                        b_r <= b_nx;
                        if (k_inc) k_r <= k_r + K_W'(1);
                        if (iter_r != '1) iter_r <= iter_r + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.gcd_out    = gcd_r;
    assign bus.iter_count = iter_r;
    assign bus.zero_in    = zero_r;
endmodule

// File: tb/tb_gcd_engine_param.sv
// Bench for gcd_engine_param: three instances (16/16, 8/8, 8/4) share one 8-bit operand
// stream; expected results come from a behavioural GCD model through a scoreboard queue.
module tb_gcd_engine_param;
    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] g;
        logic [63:0] it [3];
        logic        z;
    } exp_t;

    exp_t sb[$];

    gcd_engine_param_if #(.WIDTH(16), .CNT_W(16)) if16 ();
    gcd_engine_param_if #(.WIDTH(8),  .CNT_W(8))  if8  ();
    gcd_engine_param_if #(.WIDTH(8),  .CNT_W(4))  if4  ();

    gcd_engine_param #(.WIDTH(16), .CNT_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    gcd_engine_param #(.WIDTH(8),  .CNT_W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    gcd_engine_param #(.WIDTH(8),  .CNT_W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

    assign if16.start = start;
    assign if16.mode  = mode;
    assign if16.a_in  = {8'h00, a};
    assign if16.b_in  = {8'h00, b};
    assign if8.start  = start;
    assign if8.mode   = mode;
    assign if8.a_in   = a;
    assign if8.b_in   = b;
    assign if4.start  = start;
    assign if4.mode   = mode;
    assign if4.a_in   = a;
    assign if4.b_in   = b;

    logic        done_v [3];
    logic        busy_v [3];
    logic        zero_v [3];
    logic [63:0] gcd_v  [3];
    logic [63:0] iter_v [3];

    assign done_v[0] = if16.done;
    assign done_v[1] = if8.done;
    assign done_v[2] = if4.done;
    assign busy_v[0] = if16.busy;
    assign busy_v[1] = if8.busy;
    assign busy_v[2] = if4.busy;
    assign zero_v[0] = if16.zero_in;
    assign zero_v[1] = if8.zero_in;
    assign zero_v[2] = if4.zero_in;
    assign gcd_v[0]  = 64'(if16.gcd_out);
    assign gcd_v[1]  = 64'(if8.gcd_out);
    assign gcd_v[2]  = 64'(if4.gcd_out);
    assign iter_v[0] = 64'(if16.iter_count);
    assign iter_v[1] = 64'(if8.iter_count);
    assign iter_v[2] = 64'(if4.iter_count);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: arithmetic GCD walk, counts saturated per instance counter width.
    function automatic exp_t make_exp(input logic m, input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        logic [63:0] x, y, raw, sat;
        int unsigned k;
        x = 64'(av); y = 64'(bv); k = 0; raw = 0;
        if (x == 0 || y == 0) begin
            e.g = x + y;
            e.z = 1'b1;
        end else begin
            e.z = 1'b0;
            while (x != y && raw < 100000) begin
                if (!m) begin
                    if (x > y) x = x - y; else y = y - x;
                end else if (x % 2 == 0 && y % 2 == 0) begin
                    x = x / 2; y = y / 2; k++;
                end else if (x % 2 == 0) begin
                    x = x / 2;
                end else if (y % 2 == 0) begin
                    y = y / 2;
                end else if (x > y) begin
                    x = x - y;
                end else begin
                    y = y - x;
                end
                raw++;
            end
            e.g = x * (64'd1 << k);
        end
        for (int i = 0; i < 3; i++) begin
            sat = (64'd1 << ((i == 0) ? 16 : (i == 1) ? 8 : 4)) - 1;
            e.it[i] = (raw > sat) ? sat : raw;
        end
        return e;
    endfunction

    // Pulse start for one cycle; returns at the falling edge after the accepting edge.
    task automatic start_op(input logic m, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        start = 1'b1; mode = m; a = av; b = bv;
        sb.push_back(make_exp(m, av, bv));
        @(negedge clk);
        start = 1'b0; mode = ~m; a = 8'($urandom); b = 8'($urandom);
    endtask

    // Edges counted inclusively from the accepting edge to the edge that raised done.
    task automatic wait_done(output int edges, output int busy_cycles, output bit timed_out);
        edges = 1; busy_cycles = 0; timed_out = 1'b0;
        while (!done_v[0]) begin
            if (busy_v[0]) busy_cycles++;
            if (edges >= 2000) begin
                timed_out = 1'b1;
                return;
            end
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || gcd_v[i] !== 64'd0 ||
                iter_v[i] !== 64'd0 || zero_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: busy=%b done=%b gcd=%0d iter=%0d zero=%b, expected all 0",
                         i, busy_v[i], done_v[i], gcd_v[i], iter_v[i], zero_v[i]);
            end
        end
    endtask

    task automatic test_subtractive;
        logic [7:0] ops [3][2] = '{'{8'd143, 8'd78}, '{8'd48, 8'd18}, '{8'd100, 8'd75}};
        int edges, busy_cycles;
        bit to;
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            start_op(1'b0, ops[n][0], ops[n][1]);
            wait_done(edges, busy_cycles, to);
            e = sb.pop_front();
            checks++;
            if (to || edges != int'(e.it[0]) + 2 || busy_cycles != int'(e.it[0]) + 1) begin
                errors++;
                $display("FAIL sub_timing op%0d: edges=%0d busy=%0d timeout=%b, expected edges=%0d busy=%0d",
                         n, edges, busy_cycles, to, e.it[0] + 2, e.it[0] + 1);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gcd_v[i] !== e.g || iter_v[i] !== e.it[i] || zero_v[i] !== e.z) begin
                    errors++;
                    $display("FAIL sub_result op%0d dut%0d: gcd=%0d iter=%0d zero=%b, expected gcd=%0d iter=%0d zero=%b",
                             n, i, gcd_v[i], iter_v[i], zero_v[i], e.g, e.it[i], e.z);
                end
            end
            if (n == 0) begin
                checks++;
                if (gcd_v[0] !== 64'd13 || iter_v[0] !== 64'd6 || edges != 8 || busy_cycles != 7) begin
                    errors++;
                    $display("FAIL sub_143_78: gcd=%0d iter=%0d edges=%0d busy=%0d, expected 13 6 8 7",
                             gcd_v[0], iter_v[0], edges, busy_cycles);
                end
            end
        end
    endtask

    task automatic test_binary;
        logic [7:0] ops [3][2] = '{'{8'd143, 8'd78}, '{8'd48, 8'd18}, '{8'd255, 8'd1}};
        logic [63:0] want_g [3] = '{64'd13, 64'd6, 64'd1};
        int edges, busy_cycles;
        bit to;
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            start_op(1'b1, ops[n][0], ops[n][1]);
            wait_done(edges, busy_cycles, to);
            e = sb.pop_front();
            checks++;
            if (to || edges != int'(e.it[0]) + 2 || busy_cycles != int'(e.it[0]) + 1) begin
                errors++;
                $display("FAIL bin_timing op%0d: edges=%0d busy=%0d timeout=%b, expected edges=%0d busy=%0d",
                         n, edges, busy_cycles, to, e.it[0] + 2, e.it[0] + 1);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gcd_v[i] !== e.g || gcd_v[i] !== want_g[n] || iter_v[i] !== e.it[i] || zero_v[i] !== e.z) begin
                    errors++;
                    $display("FAIL bin_result op%0d dut%0d: gcd=%0d iter=%0d zero=%b, expected gcd=%0d iter=%0d zero=%b",
                             n, i, gcd_v[i], iter_v[i], zero_v[i], want_g[n], e.it[i], e.z);
                end
            end
        end
    endtask

    task automatic test_zero;
        logic [7:0] ops [3][2] = '{'{8'd0, 8'd91}, '{8'd91, 8'd0}, '{8'd0, 8'd0}};
        int edges, busy_cycles;
        bit to;
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            start_op(1'(n), ops[n][0], ops[n][1]);
            wait_done(edges, busy_cycles, to);
            e = sb.pop_front();
            checks++;
            if (to || edges != 1 || busy_cycles != 0) begin
                errors++;
                $display("FAIL zero_timing op%0d: edges=%0d busy=%0d timeout=%b, expected edges=1 busy=0",
                         n, edges, busy_cycles, to);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gcd_v[i] !== e.g || iter_v[i] !== 64'd0 || zero_v[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL zero_result op%0d dut%0d: gcd=%0d iter=%0d zero=%b, expected gcd=%0d iter=0 zero=1",
                             n, i, gcd_v[i], iter_v[i], zero_v[i], e.g);
                end
            end
        end
    endtask

    task automatic test_random;
        int edges, busy_cycles;
        bit to;
        exp_t e;
        logic m;
        logic [7:0] av, bv;
        for (int n = 0; n < 8; n++) begin
            m  = 1'($urandom_range(0, 1));
            av = 8'($urandom_range(1, 255));
            bv = 8'($urandom_range(1, 255));
            start_op(m, av, bv);
            wait_done(edges, busy_cycles, to);
            e = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (to || gcd_v[i] !== e.g || iter_v[i] !== e.it[i] || zero_v[i] !== e.z) begin
                    errors++;
                    $display("FAIL rand mode=%0b a=%0d b=%0d dut%0d: gcd=%0d iter=%0d zero=%b timeout=%b, expected gcd=%0d iter=%0d zero=%b",
                             m, av, bv, i, gcd_v[i], iter_v[i], zero_v[i], to, e.g, e.it[i], e.z);
                end
            end
        end
    endtask

    task automatic test_saturation;
        int edges, busy_cycles;
        bit to;
        exp_t e;
        start_op(1'b0, 8'd255, 8'd1);
        wait_done(edges, busy_cycles, to);
        e = sb.pop_front();
        checks++;
        if (to || gcd_v[1] !== 64'd1 || iter_v[1] !== 64'd254 || gcd_v[2] !== 64'd1 || iter_v[2] !== 64'd15) begin
            errors++;
            $display("FAIL saturation: dut8 gcd=%0d iter=%0d, dut4 gcd=%0d iter=%0d, timeout=%b, expected 1 254 1 15",
                     gcd_v[1], iter_v[1], gcd_v[2], iter_v[2], to);
        end
        checks++;
        if (edges != 256 || iter_v[0] !== e.it[0]) begin
            errors++;
            $display("FAIL saturation_timing: edges=%0d iter16=%0d, expected edges=256 iter16=%0d",
                     edges, iter_v[0], e.it[0]);
        end
    endtask

    task automatic test_ignore_start;
        int edges, busy_cycles, extra;
        bit to;
        exp_t e;
        start_op(1'b0, 8'd143, 8'd78);
        repeat (2) @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'd100; b = 8'd75;
        @(negedge clk);
        start = 1'b0;
        wait_done(edges, busy_cycles, to);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (to || gcd_v[i] !== 64'd13 || iter_v[i] !== e.it[i]) begin
                errors++;
                $display("FAIL ignore_start dut%0d: gcd=%0d iter=%0d timeout=%b, expected gcd=13 iter=%0d",
                         i, gcd_v[i], iter_v[i], to, e.it[i]);
            end
        end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_v[0] || done_v[1] || done_v[2]) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_start_queued: extra done pulses=%0d, expected 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int edges, busy_cycles;
        bit to;
        exp_t e;
        start_op(1'b0, 8'd143, 8'd78);
        wait_done(edges, busy_cycles, to);
        e = sb.pop_front();
        checks++;
        if (to || gcd_v[0] !== e.g) begin
            errors++;
            $display("FAIL b2b_first: gcd=%0d timeout=%b, expected gcd=%0d", gcd_v[0], to, e.g);
        end
        // Still inside the single DONE cycle: this start must be accepted.
        start = 1'b1; mode = 1'b1; a = 8'd48; b = 8'd18;
        sb.push_back(make_exp(1'b1, 8'd48, 8'd18));
        @(negedge clk);
        start = 1'b0; a = 8'd7; b = 8'd3; mode = 1'b0;
        wait_done(edges, busy_cycles, to);
        e = sb.pop_front();
        checks++;
        if (to || edges != 8 || busy_cycles != 7) begin
            errors++;
            $display("FAIL b2b_timing: edges=%0d busy=%0d timeout=%b, expected 8 7", edges, busy_cycles, to);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gcd_v[i] !== 64'd6 || iter_v[i] !== e.it[i] || zero_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_second dut%0d: gcd=%0d iter=%0d zero=%b, expected gcd=6 iter=%0d zero=0",
                         i, gcd_v[i], iter_v[i], zero_v[i], e.it[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int edges, busy_cycles, extra;
        bit to;
        exp_t e;
        start_op(1'b0, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || gcd_v[i] !== 64'd0 ||
                iter_v[i] !== 64'd0 || zero_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid dut%0d: busy=%b done=%b gcd=%0d iter=%0d zero=%b, expected all 0",
                         i, busy_v[i], done_v[i], gcd_v[i], iter_v[i], zero_v[i]);
            end
        end
        extra = 0;
        repeat (250) begin
            @(negedge clk);
            if (done_v[0] || done_v[1] || done_v[2] || busy_v[0]) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL reset_mid_abort: cycles with done/busy=%0d, expected 0", extra);
        end
        start_op(1'b1, 8'd143, 8'd78);
        wait_done(edges, busy_cycles, to);
        e = sb.pop_front();
        checks++;
        if (to || gcd_v[0] !== 64'd13 || iter_v[0] !== e.it[0]) begin
            errors++;
            $display("FAIL reset_mid_restart: gcd=%0d iter=%0d timeout=%b, expected gcd=13 iter=%0d",
                     gcd_v[0], iter_v[0], to, e.it[0]);
        end
    endtask

    initial begin
        test_reset();
        test_subtractive();
        test_binary();
        test_zero();
        test_random();
        test_saturation();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
